// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// The master drives the operands and out_ready; the slave (the adder) answers with results.
interface add_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder: one SLICE-bit slice per stage, valid/ready with a global stall.
// Optional subtraction is enabled by defining ADD_PIPE_SUB_EN.
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_pipe_if.slave     bus
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("add_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef ADD_PIPE_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.cin ^ bus.sub;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    // A full output register that is not being taken freezes every stage, bubbles included.
    assign adv          = !stg[LAST].v_r || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage k consumes the lowest remaining operand slice; only unconsumed bits travel on.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO   = k * SLICE;
        localparam int DONE = (k + 1) * SLICE;

        logic [WIDTH-LO-1:0] a_i;
        logic [WIDTH-LO-1:0] b_i;
        logic                c_i;
        logic                v_i;
        logic [DONE-1:0]     s_d;
        logic [SLICE:0]      part;

        logic                v_r;
        logic                c_r;
        logic [DONE-1:0]     s_r;

        if (k == 0) begin : g_src
            assign a_i = bus.a;
            assign b_i = b_eff;
            assign c_i = cin_eff;
            assign v_i = bus.in_valid;
        end else begin : g_src
            assign a_i = stg[k-1].g_fwd.a_r;
            assign b_i = stg[k-1].g_fwd.b_r;
            assign c_i = stg[k-1].c_r;
            assign v_i = stg[k-1].v_r;
        end

        assign part = {1'b0, a_i[SLICE-1:0]} + {1'b0, b_i[SLICE-1:0]} + {{SLICE{1'b0}}, c_i};

        if (k == 0) begin : g_sum
            assign s_d = part[SLICE-1:0];
        end else begin : g_sum
            assign s_d = {part[SLICE-1:0], stg[k-1].s_r};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (adv) begin
                v_r <= v_i;
                c_r <= part[SLICE];
                s_r <= s_d;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [WIDTH-DONE-1:0] a_r;
            logic [WIDTH-DONE-1:0] b_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv) begin
                    a_r <= a_i[WIDTH-LO-1:SLICE];
                    b_r <= b_i[WIDTH-LO-1:SLICE];
                end
            end
        end else begin : g_fin
            logic ovf_r;
            logic c_msb;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign c_msb = a_i[SLICE-1] ^ b_i[SLICE-1] ^ part[SLICE-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (adv) begin
                    ovf_r <= c_msb ^ part[SLICE];
                end
            end
        end
    end

    assign bus.out_valid = stg[LAST].v_r;
    assign bus.sum       = stg[LAST].s_r;
    assign bus.cout      = stg[LAST].c_r;
    assign bus.ovf       = stg[LAST].g_fin.ovf_r;

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: W16/S4 and W8/S1 instances against an arithmetic model.
// Honours ADD_PIPE_SUB_EN the same way as the design build.
module tb_add_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

`ifdef ADD_PIPE_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    add_pipe_if #(.WIDTH(16)) bus16 ();
    add_pipe_if #(.WIDTH(8))  bus8  ();

    add_pipe #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    add_pipe #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} using plain integer arithmetic on a w-bit word.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        longint unsigned mask, beff, total, s;
        logic s_on, co, sa, sb, ss, ov;
        mask  = (64'd1 << w) - 64'd1;
        s_on  = SUB_EN && sub;
        beff  = s_on ? (~{32'd0, b}) & mask : {32'd0, b};
        total = {32'd0, a} + beff + {63'd0, (cin ^ s_on)};
        s     = total & mask;
        co    = total[w];
        sa    = a[w-1];
        sb    = beff[w-1];
        ss    = s[w-1];
        ov    = (sa == sb) && (ss != sa);
        return {ov, co, s[31:0]};
    endfunction

    // One cycle on the W16 pipe; inputs already set. Scores outputs and records accepted ops.
    task automatic step16(output bit took);
        logic [33:0] r;
        logic [17:0] e;
        #1;
        check_val("in_ready_rule", bus16.in_ready, (!bus16.out_valid || bus16.out_ready));
        if (bus16.out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", bus16.out_valid, 1'b0);
            end else begin
                e = exp_q[0];
                check_val("sum",  bus16.sum,  e[15:0]);
                check_val("cout", bus16.cout, e[16]);
                check_val("ovf",  bus16.ovf,  e[17]);
                if (bus16.out_ready) void'(exp_q.pop_front());
            end
        end
        took = bus16.in_valid && bus16.in_ready;
        if (took) begin
            r = ref_add(16, {16'd0, bus16.a}, {16'd0, bus16.b}, bus16.cin, bus16.sub);
            exp_q.push_back({r[33], r[32], r[15:0]});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed16(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub,
                              input logic [15:0] es, input logic ec, input logic eo);
        bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, bus16.in_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        bus16.in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            check_val({tag, "_early_valid"}, bus16.out_valid, 1'b0);
            @(posedge clk); @(negedge clk);
        end
        #1;
        check_val({tag, "_valid"}, bus16.out_valid, 1'b1);
        check_val({tag, "_sum"},   bus16.sum,  es);
        check_val({tag, "_cout"},  bus16.cout, ec);
        check_val({tag, "_ovf"},   bus16.ovf,  eo);
        @(posedge clk); @(negedge clk);
        #1;
        check_val({tag, "_drained"}, bus16.out_valid, 1'b0);
    endtask

    task automatic drain16(input string tag);
        bit took;
        int n;
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step16(took);
            n++;
        end
        check_val({tag, "_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took;
        int issued;
        int c;
        logic [33:0] r8;

        rst_n = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus16.sub = 1'b0; bus16.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus8.sub = 1'b0; bus8.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", bus16.out_valid, 1'b0);
        check_val("rst_sum",       bus16.sum, 16'h0000);
        check_val("rst_cout",      bus16.cout, 1'b0);
        check_val("rst_ovf",       bus16.ovf, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("rst_in_ready", bus16.in_ready, 1'b1);
        @(negedge clk);

        directed16("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed16("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed16("cin_add",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
`ifdef ADD_PIPE_SUB_EN
        directed16("sub_3_5",     16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed16("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`else
        directed16("sub_ignored", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0);
`endif

        // Back-to-back stream with the consumer stalling in cycles 5..7.
        issued = 0;
        c = 0;
        while ((issued < 8 || exp_q.size() != 0) && c < 40) begin
            bus16.in_valid  = (issued < 8);
            bus16.a         = 16'($urandom);
            bus16.b         = 16'($urandom);
            bus16.cin       = 1'($urandom);
            bus16.sub       = 1'($urandom);
            bus16.out_ready = !(c >= 5 && c <= 7);
            if (c >= 5 && c <= 7) begin
                #1;
                check_val("stall_in_ready", bus16.in_ready, 1'b0);
            end
            if (c >= 4 && exp_q.size() != 0) begin
                #1;
                check_val("stream_no_gap", bus16.out_valid, 1'b1);
            end
            step16(took);
            if (took) issued++;
            c++;
        end
        check_val("stream_issued", issued, 8);
        check_val("stream_left", exp_q.size(), 0);

        // Random traffic with random backpressure and boundary operands mixed in.
        for (int i = 0; i < 400; i++) begin
            bus16.in_valid  = ($urandom_range(3) != 0);
            bus16.out_ready = ($urandom_range(2) != 0);
            case ($urandom_range(5))
                0: bus16.a = 16'hFFFF;
                1: bus16.a = 16'h8000;
                2: bus16.a = 16'h7FFF;
                default: bus16.a = 16'($urandom);
            endcase
            case ($urandom_range(5))
                0: bus16.b = 16'hFFFF;
                1: bus16.b = 16'h0001;
                2: bus16.b = 16'h8000;
                default: bus16.b = 16'($urandom);
            endcase
            bus16.cin = 1'($urandom);
            bus16.sub = 1'($urandom);
            step16(took);
        end
        drain16("random_drain");

        // Reset while three ops are in flight and the first one is already presented.
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a = 16'h0101 + 16'(i);
            bus16.b = 16'h1010;
            bus16.cin = 1'b0;
            bus16.sub = 1'b0;
            step16(took);
        end
        bus16.in_valid = 1'b0;
        step16(took);
        #1;
        check_val("pre_reset_valid", bus16.out_valid, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", bus16.out_valid, 1'b0);
        check_val("midrst_sum",       bus16.sum, 16'h0000);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_val("post_reset_stale", bus16.out_valid, 1'b0);
            @(posedge clk); @(negedge clk);
        end
        directed16("post_reset_op", 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Single-stage 8-bit instance: one-cycle latency and full rate with out_ready held.
        bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus8.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        check_val("s1_valid", bus8.out_valid, 1'b1);
        check_val("s1_sum",   bus8.sum, 8'h00);
        check_val("s1_cout",  bus8.cout, 1'b1);
        check_val("s1_ovf",   bus8.ovf, 1'b1);
        for (int i = 0; i < 12; i++) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
            #1;
            check_val("s1_in_ready", bus8.in_ready, 1'b1);
            r8 = ref_add(8, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.cin, bus8.sub);
            @(posedge clk); @(negedge clk);
            #1;
            check_val("s1_rate_valid", bus8.out_valid, 1'b1);
            check_val("s1_rate_sum",   bus8.sum, r8[7:0]);
            check_val("s1_rate_cout",  bus8.cout, r8[32]);
            check_val("s1_rate_ovf",   bus8.ovf, r8[33]);
        end
        bus8.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        check_val("s1_empty", bus8.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
